rr_burst_scheduler: RTL and testbench
=====================================

Name: rr_burst_scheduler

Overview:
- Shares one beat-oriented resource (bus port, memory bank, FIFO write side) among N_REQ requesters.
- A requester owns the resource for a whole tenure of beats, not a single cycle.
- Owners are picked round-robin. The pointer advances past the actual winner, giving true rotation.
- A beat cap (MAX_BEATS) stops one requester from monopolising the resource. Sits between requester front-ends and the shared resource's valid/ready port.

Parameters:
N_REQ, 4, number of requesters (2..16)
MAX_BEATS, 8, maximum accepted beats per tenure before forced release (1..256)
ID_W, $clog2(N_REQ), derived width of grant_id
CNT_W, $clog2(MAX_BEATS+1), derived width of beat_cnt

Ports:
clk  input  1  single clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
req  input  N_REQ  per-requester resource request; holds high for the whole tenure
req_last  input  N_REQ  marks the owner's current beat as the final beat of its transaction
bus_ready  input  1  shared resource accepts a beat this cycle
grant  output  N_REQ  registered one-hot ownership, all-zero when idle
grant_id  output  ID_W  binary index of the owner; valid only while busy=1
busy  output  1  high while a tenure is active (equals |grant)
beat_cnt  output  CNT_W  beats accepted in the current tenure
preempt  output  1  one-cycle pulse on the tenure-ending cycle when MAX_BEATS forced release
abort  output  1  one-cycle pulse on the cycle the owner drops req without a last beat

Behaviour:
- Reset (reset_n=0, async): grant=0, grant_id=0, busy=0, beat_cnt=0, preempt=0, abort=0, state=IDLE, ptr=0. Takes effect immediately, including mid-tenure. No partial beat counting survives reset.
- States: IDLE, OWN.
- Arbitration (combinational on current req): search indices ptr, ptr+1, ..., ptr+N_REQ-1 mod N_REQ; the first set bit wins.
- IDLE: if |req, register the winner next edge (grant one-hot, grant_id, busy=1, beat_cnt=0) -> OWN. Request-to-grant latency is 1 cycle. If req=0, stay IDLE.
- OWN, beat definition: beat = bus_ready & req[owner]. Each beat increments beat_cnt.
- OWN, tenure end conditions, evaluated on the same cycle:
  - (a) beat & req_last[owner]: normal end.
  - (b) beat & (beat_cnt == MAX_BEATS-1): preempt=1 unless (a) also holds; (a) has priority, so no preempt pulse.
  - (c) !req[owner]: abort=1, no beat counted.
- On tenure end:
  - ptr <= owner+1 mod N_REQ.
  - Arbitration runs in the same cycle on current req, using the new rotation (search starts at owner+1).
  - If any req is set, the new grant appears on the next edge (zero-bubble handoff), beat_cnt=0, stay OWN. The old owner may be re-granted only if no other requester is active.
  - If no req is set: grant=0, busy=0 next edge -> IDLE.
- Stall: bus_ready=0 holds the owner, beat_cnt and the pointer indefinitely. There is no timeout.
- req from non-owners during OWN is ignored until tenure end.
- req_last from a non-owner, or while bus_ready=0, is ignored.
- ptr changes only on tenure end, never in IDLE.
- grant is always one-hot or zero. Never multi-hot, including across handoff.
- beat_cnt never exceeds MAX_BEATS-1 while visible. It is cleared on every new grant.
- preempt and abort are registered pulses aligned to the cycle after the ending event. They are mutually exclusive.

Test Plan:
- Reset then idle: reset_n low mid-sim with req=4'b1111 -> grant=0, busy=0 immediately. After release, grant=4'b0001 exactly 1 cycle later.
- Single burst: req=4'b0100, bus_ready=1, req_last on the 3rd beat -> grant=4'b0100, beat_cnt 0->1->2, then grant=0, busy=0, ptr=3. No preempt or abort.
- Rotation: req=4'b1111 held, each tenure 1 beat with last -> grant sequence 0001, 0010, 0100, 1000, 0001, with back-to-back handoff and no idle cycle.
- Preemption: MAX_BEATS=8, req=4'b0011 with requester 0 never asserting last -> 8 beats accepted, preempt pulses once, grant moves to 4'b0010. Same test with last on beat 8 -> no preempt.
- Stall and abort: owner 1 with bus_ready=0 for 20 cycles -> beat_cnt frozen, grant stable. Owner drops req mid-burst -> abort pulse, next requester granted, ptr=2.
- Async reset mid-tenure: assert reset_n=0 at beat_cnt=5 between clock edges -> all outputs zero before the next edge. Post-reset arbitration restarts at requester 0.

Source files
------------

// File: rtl/rr_burst_scheduler.sv
// rr_burst_scheduler: gives one shared beat-oriented resource to one of N_REQ
// requesters at a time. Ownership lasts for a whole tenure of beats. Owners are
// chosen round-robin, starting just past the previous owner. A tenure ends on
// a last beat, when the MAX_BEATS cap is reached, or when the owner drops req.
module rr_burst_scheduler #(
  parameter int N_REQ     = 4,
  parameter int MAX_BEATS = 8,
  parameter int ID_W      = $clog2(N_REQ),
  parameter int CNT_W     = $clog2(MAX_BEATS+1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_last,
  input  logic             bus_ready,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             preempt,
  output logic             abort
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state;
  logic [ID_W-1:0] ptr;

  logic            owner_req, owner_last, beat;
  logic            end_last, end_cap, end_abort, ten_end;
  logic [ID_W-1:0] nxt, start, win_id;
  logic            win_vld;

  // Owner-side tenure-end decode and the index just past the current owner
  always_comb begin
    owner_req  = req[grant_id];
    owner_last = req_last[grant_id];
    beat       = (state == OWN) && bus_ready && owner_req;
    end_last   = beat && owner_last;
    end_cap    = beat && (beat_cnt == CNT_W'(MAX_BEATS-1));
    end_abort  = (state == OWN) && !owner_req;
    ten_end    = end_last || end_cap || end_abort;
    nxt        = (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + ID_W'(1);
  end

  // Rotating priority search. While owning, the search always starts past the
  // owner, so the result is ready to use as the handoff winner on tenure end.
  always_comb begin
    start   = (state == OWN) ? nxt : ptr;
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int              k;
      logic [ID_W-1:0] idx;
      k = int'(start) + i;
      if (k >= N_REQ) k = k - N_REQ;
      idx = ID_W'(k);
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  // Ownership FSM with registered grant, counter and end-of-tenure pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ptr      <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      beat_cnt <= '0;
      preempt  <= 1'b0;
      abort    <= 1'b0;
    end else begin
      preempt <= 1'b0;
      abort   <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            grant    <= N_REQ'(1) << win_id;
            grant_id <= win_id;
            busy     <= 1'b1;
            beat_cnt <= '0;
            state    <= OWN;
          end
        end
        OWN: begin
          if (ten_end) begin
            ptr      <= nxt;
            beat_cnt <= '0;
            // a last beat on the capped beat is a normal end, not a preemption
            preempt  <= end_cap && !end_last;
            abort    <= end_abort;
            if (win_vld) begin
              grant    <= N_REQ'(1) << win_id;
              grant_id <= win_id;
            end else begin
              grant    <= '0;
              grant_id <= '0;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end else if (beat) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Bench for rr_burst_scheduler: directed scenarios followed by a random phase.
// Every cycle is compared against a tenure-level reference model.
module tb_rr_burst_scheduler;
  localparam int N    = 4;
  localparam int MAXB = 8;
  localparam int IDW  = 2;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [N-1:0]  req = '0, req_last = '0;
  logic          bus_ready = 1'b0;
  logic [N-1:0]  grant;
  logic [IDW-1:0] grant_id;
  logic          busy;
  logic [CW-1:0] beat_cnt;
  logic          preempt, abort;

  int passed = 0, total = 0, fails = 0;

  // reference model: who owns the resource, beats taken so far, next search start
  int m_owner = -1, m_cnt = 0, m_ptr = 0;
  bit m_pre = 0, m_abt = 0;

  always #5 clk = ~clk;

  rr_burst_scheduler #(.N_REQ(N), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_last(req_last),
    .bus_ready(bus_ready), .grant(grant), .grant_id(grant_id), .busy(busy),
    .beat_cnt(beat_cnt), .preempt(preempt), .abort(abort)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int from, input logic [N-1:0] r);
    for (int i = 0; i < N; i++)
      if (r[(from + i) % N]) return (from + i) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_ptr = 0; m_pre = 0; m_abt = 0;
  endtask

  // one clock of the tenure rules, using the inputs about to be sampled
  task automatic model_step();
    bit done;
    done  = 0;
    m_pre = 0;
    m_abt = 0;
    if (m_owner < 0) begin
      m_owner = pick(m_ptr, req);
      m_cnt   = 0;
    end else begin
      if (!req[m_owner]) begin
        m_abt = 1; done = 1;
      end else if (bus_ready) begin
        if (req_last[m_owner]) done = 1;
        else if (m_cnt + 1 == MAXB) begin done = 1; m_pre = 1; end
        else m_cnt++;
      end
      if (done) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = pick(m_ptr, req);
        m_cnt   = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s.grant", tag), 32'(grant), (m_owner < 0) ? 0 : (1 << m_owner));
    chk($sformatf("%s.busy", tag), 32'(busy), (m_owner >= 0) ? 1 : 0);
    chk($sformatf("%s.beat_cnt", tag), 32'(beat_cnt), m_cnt);
    chk($sformatf("%s.preempt", tag), 32'(preempt), 32'(m_pre));
    chk($sformatf("%s.abort", tag), 32'(abort), 32'(m_abt));
    if (m_owner >= 0) chk($sformatf("%s.grant_id", tag), 32'(grant_id), m_owner);
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    // power-on reset
    #1 reset_n = 1'b0;
    #2 model_reset();
    check_all("por");
    @(negedge clk) reset_n = 1'b1;
    repeat (2) step("idle");

    // reset mid-sim with all requesting: outputs clear at once, then 0 wins
    req = 4'b1111;
    step("pre_rst");
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all("rst_async");
    @(negedge clk) reset_n = 1'b1;
    step("rst_release");
    chk("rst_first_grant", 32'(grant), 32'h1);
    req = 4'b0000;
    step("rst_drop");

    // single burst on requester 2, last on the third beat
    req = 4'b0100; bus_ready = 1'b1; req_last = '0;
    step("burst_grant");
    step("burst_b1");
    step("burst_b2");
    chk("burst_cnt2", 32'(beat_cnt), 32'd2);
    req_last = 4'b0100; req = 4'b1101;
    step("burst_end");
    chk("burst_ptr3", 32'(grant), 32'h8);
    req_last = '0; req = '0;
    step("burst_idle");

    // rotation: single-beat tenures, back-to-back
    req = 4'b1111; req_last = 4'b1111;
    step("rot_first");
    chk("rot_0", 32'(grant), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      step("rot");
      chk($sformatf("rot_%0d", i), 32'(grant), 32'(1 << (i % N)));
    end
    req = '0; req_last = '0;
    step("rot_idle");

    // preemption of requester 1 after MAX_BEATS beats
    req = 4'b0011; bus_ready = 1'b1;
    step("pre_grant");
    repeat (MAXB - 1) step("pre_beat");
    chk("pre_cnt_max", 32'(beat_cnt), 32'(MAXB - 1));
    step("pre_end");
    chk("pre_pulse", 32'(preempt), 32'd1);
    chk("pre_next", 32'(grant), 32'h1);
    // requester 0: last on the capping beat ends normally
    repeat (MAXB - 1) step("cap_beat");
    req_last = 4'b0001;
    step("cap_last");
    chk("cap_no_pre", 32'(preempt), 32'd0);
    chk("cap_next", 32'(grant), 32'h2);
    req_last = '0;

    // stall owner 1 for 20 cycles, then abort
    step("stall_b1");
    bus_ready = 1'b0;
    repeat (20) step("stall");
    chk("stall_cnt", 32'(beat_cnt), 32'd1);
    chk("stall_grant", 32'(grant), 32'h2);
    bus_ready = 1'b1; req = 4'b1101;
    step("abort");
    chk("abort_pulse", 32'(abort), 32'd1);
    chk("abort_next", 32'(grant), 32'h4);

    // async reset mid-tenure at beat_cnt 5
    repeat (5) step("mid_beat");
    chk("mid_cnt5", 32'(beat_cnt), 32'd5);
    req = 4'b1111;
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all("mid_rst");
    @(negedge clk) reset_n = 1'b1;
    step("mid_release");
    chk("mid_restart", 32'(grant), 32'h1);

    // random traffic: requests mostly held, occasional last, ready mostly high
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      req_last  = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
      bus_ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
